// File: rtl/stopwatch_ctrl.sv
// Start/stop and lap/reset button controller for a stopwatch display.
// Short lap presses toggle the lap freeze; a long lap hold clears the counters.
module stopwatch_ctrl #(
  parameter logic [23:0] LONG_CYCLES = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       lap_btn,
  output logic       run,
  output logic       lap_hold,
  output logic       clear,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StLap  = 2'b10,
    StStop = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic        clear_d;
  logic        start_prev_q, lap_prev_q;
  logic        armed_q;
  logic [23:0] hold_cnt_q;

  logic start_press, lap_press, lap_rel, long_hit, rel_ok;

  assign start_press = start_btn & ~start_prev_q;
  assign lap_press   = lap_btn & ~lap_prev_q;
  assign lap_rel     = ~lap_btn & lap_prev_q;
  // The press cycle itself counts as the first held cycle.
  assign long_hit    = armed_q & lap_btn & (hold_cnt_q == LONG_CYCLES - 24'd1);
  assign rel_ok      = armed_q & lap_rel & (hold_cnt_q < LONG_CYCLES);
  assign state       = state_q;

  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_press)    state_d = StRun;
        else if (lap_press) clear_d = 1'b1;
      end
      StRun, StLap: begin
        if (start_press) begin
          state_d = StStop;
        end else if (long_hit) begin
          clear_d = 1'b1;
          state_d = StIdle;
        end else if (rel_ok) begin
          state_d = (state_q == StRun) ? StLap : StRun;
        end
      end
      StStop: begin
        if (start_press) begin
          state_d = StRun;
        end else if (lap_press) begin
          clear_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      run          <= 1'b0;
      lap_hold     <= 1'b0;
      clear        <= 1'b0;
      start_prev_q <= 1'b1;
      lap_prev_q   <= 1'b1;
      armed_q      <= 1'b0;
      hold_cnt_q   <= 24'd0;
    end else begin
      start_prev_q <= start_btn;
      lap_prev_q   <= lap_btn;
      if (lap_press) begin
        hold_cnt_q <= 24'd1;
        // A lap press coinciding with a start press is discarded entirely.
        armed_q    <= ~start_press;
      end else if (lap_rel) begin
        armed_q <= 1'b0;
      end else if (armed_q && lap_btn) begin
        hold_cnt_q <= hold_cnt_q + 24'd1;
        if (long_hit) armed_q <= 1'b0;
      end
      state_q  <= state_d;
      clear    <= clear_d & ~clear;
      run      <= (state_d == StRun) || (state_d == StLap);
      lap_hold <= (state_d == StLap);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus randomized button traffic
// checked against an event-level model of the button rules.
module tb_stopwatch_ctrl;
  localparam int LONG = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_btn = 1'b0;
  logic       lap_btn = 1'b0;
  logic       run, lap_hold, clear;
  logic [1:0] state;

  stopwatch_ctrl #(.LONG_CYCLES(24'd16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_btn (start_btn),
    .lap_btn   (lap_btn),
    .run       (run),
    .lap_hold  (lap_hold),
    .clear     (clear),
    .state     (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: states 0 idle, 1 run, 2 lap, 3 stop; long press judged from press time.
  int   m_state, m_cyc, m_press_cyc;
  logic m_run, m_hold, m_clear, m_ps, m_pl, m_armed;

  wire [4:0] dut_vec = {state, run, lap_hold, clear};

  function automatic logic [4:0] exp_vec();
    logic [1:0] st;
    st = m_state[1:0];
    return {st, m_run, m_hold, m_clear};
  endfunction

  task automatic model_reset();
    m_state = 0; m_run = 0; m_hold = 0; m_clear = 0;
    m_ps = 1; m_pl = 1; m_armed = 0; m_press_cyc = 0;
  endtask

  task automatic model_step(input logic s, input logic l);
    logic ps, pl, rl, lg, rok, clr;
    int held, ns;
    ps = s && !m_ps;
    pl = l && !m_pl;
    rl = !l && m_pl;
    held = m_cyc - m_press_cyc + 1;
    lg = m_armed && l && (held == LONG);
    rok = m_armed && rl;
    ns = m_state;
    clr = 0;
    case (m_state)
      0: if (ps) ns = 1; else if (pl) clr = 1;
      1, 2: begin
        if (ps) ns = 3;
        else if (lg) begin clr = 1; ns = 0; end
        else if (rok) ns = (m_state == 1) ? 2 : 1;
      end
      default: begin
        if (ps) ns = 1;
        else if (pl) begin clr = 1; ns = 0; end
      end
    endcase
    if (pl) begin m_armed = !ps; m_press_cyc = m_cyc; end
    if (lg || rl) m_armed = 0;
    m_clear = clr && !m_clear;
    m_state = ns;
    m_run = (ns == 1) || (ns == 2);
    m_hold = (ns == 2);
    m_ps = s;
    m_pl = l;
    m_cyc++;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic cycle(input logic s, input logic l);
    start_btn = s;
    lap_btn = l;
    @(posedge clk);
    model_step(s, l);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", dut_vec, 5'b0);
    end
    @(negedge clk);
    rst_n = 1;
    cycle(0, 0);
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_start_stop();
    cycle(1, 0);
    n_cmp++;
    if (state !== 2'b01 || run !== 1'b1) begin
      n_fail++;
      $display("FAIL start_run: got state=%b run=%b want 01/1", state, run);
    end
    cycle(0, 0);
    cycle(1, 0);
    n_cmp++;
    if (state !== 2'b11 || run !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop: got state=%b run=%b want 11/0", state, run);
    end
    cycle(0, 0);
  endtask

  task automatic test_lap();
    cycle(1, 0);
    cycle(0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        cycle(0, 1);
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
          n_fail++;
          $display("FAIL lap_holding r%0d c%0d: got %b want %b", r, i, dut_vec, exp_vec());
        end
      end
      cycle(0, 0);
      n_cmp++;
      if (r == 0 && (state !== 2'b10 || lap_hold !== 1'b1 || run !== 1'b1)) begin
        n_fail++;
        $display("FAIL lap_enter: got st=%b hold=%b run=%b want 10/1/1", state, lap_hold, run);
      end else if (r == 1 && (state !== 2'b01 || lap_hold !== 1'b0)) begin
        n_fail++;
        $display("FAIL lap_exit: got st=%b hold=%b want 01/0", state, lap_hold);
      end
    end
  endtask

  task automatic test_long_press();
    int pulses, at;
    pulses = 0;
    at = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle(0, 1);
      if (clear === 1'b1) begin pulses++; at = i; end
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL long_hold c%0d: got %b want %b", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (pulses != 1 || at != LONG || state !== 2'b00) begin
      n_fail++;
      $display("FAIL long_pulse: got pulses=%0d at=%0d st=%b want 1/%0d/00",
               pulses, at, state, LONG);
    end
    cycle(0, 0);
    n_cmp++;
    if (state !== 2'b00 || clear !== 1'b0) begin
      n_fail++;
      $display("FAIL long_release: got st=%b clr=%b want 00/0", state, clear);
    end
  endtask

  task automatic test_stop_clear();
    cycle(1, 0);
    cycle(0, 0);
    cycle(1, 0);
    cycle(0, 0);
    cycle(0, 1);
    n_cmp++;
    if (clear !== 1'b1 || state !== 2'b00 || run !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_clear: got clr=%b st=%b run=%b want 1/00/0", clear, state, run);
    end
    cycle(0, 1);
    n_cmp++;
    if (clear !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_width: got clr=%b want 0", clear);
    end
    cycle(0, 0);
  endtask

  task automatic test_simultaneous();
    cycle(1, 1);
    n_cmp++;
    if (state !== 2'b01 || clear !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_press: got st=%b clr=%b want 01/0", state, clear);
    end
    cycle(1, 1);
    cycle(0, 1);
    cycle(0, 0);
    n_cmp++;
    if (state !== 2'b01 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL simul_release: got %b want %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_held();
    @(negedge clk);
    rst_n = 0;
    start_btn = 1;
    lap_btn = 0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) cycle(1, 0);
    n_cmp++;
    if (state !== 2'b00 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL held_through_reset: got %b want %b", dut_vec, exp_vec());
    end
    cycle(0, 0);
    cycle(1, 0);
    n_cmp++;
    if (state !== 2'b01) begin
      n_fail++;
      $display("FAIL press_after_reset: got st=%b want 01", state);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(0, 1);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b want %b", dut_vec, 5'b0);
    end
    lap_btn = 0;
    @(negedge clk);
    rst_n = 1;
    cycle(0, 0);
    cycle(0, 0);
    n_cmp++;
    if (dut_vec !== 5'b0 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL pending_release: got %b want %b", dut_vec, 5'b0);
    end
  endtask

  task automatic test_random();
    int s_left, l_left;
    logic s, l;
    s = 0; l = 0; s_left = 0; l_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (s_left == 0) begin s = $urandom_range(0, 1); s_left = $urandom_range(1, 12); end
      if (l_left == 0) begin
        l = $urandom_range(0, 1);
        l_left = (l && $urandom_range(0, 3) == 0) ? $urandom_range(14, 25) : $urandom_range(1, 8);
      end
      s_left--;
      l_left--;
      cycle(s, l);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random c%0d s=%b l=%b: got %b want %b", i, s, l, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    test_reset();
    test_start_stop();
    test_lap();
    test_long_press();
    test_stop_clear();
    test_simultaneous();
    test_reset_held();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
